// File: rtl/core_pkg.sv
// Shared types and encodings for the RV32 pipeline hazard controller.
package core_pkg;

    typedef enum logic {
        RUN,
        MC_WAIT
    } hz_state_e;

    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one ALU source; the memory stage wins over writeback.
module forward_unit
    import core_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i == rs_e_i) && (rs_e_i != 5'd0)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i == rs_e_i) && (rs_e_i != 5'd0)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: forwarding, load-use/branch stall and flush, and
// multi-cycle execute unit handshake with timeout and stall-cycle counter.
module hazard_controller
    import core_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        rs1_d_i,
    input  logic [4:0]        rs2_d_i,
    input  logic [4:0]        rs1_e_i,
    input  logic [4:0]        rs2_e_i,
    input  logic [4:0]        rd_e_i,
    input  logic [4:0]        rd_m_i,
    input  logic [4:0]        rd_w_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    input  logic [1:0]        result_src_e_i,
    input  logic              pc_src_e_i,
    input  logic              mc_op_e_i,
    input  logic              mc_done_i,
    output logic              mc_start_o,
    output logic [1:0]        forward_ae_o,
    output logic [1:0]        forward_be_o,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              flush_m_o,
    output logic              mc_timeout_o,
    output logic [PERF_W-1:0] stall_count_o
);

    localparam int unsigned    TW         = $clog2(MC_TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(MC_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PERF_W-1:0] count_q;
    logic              timeout_q, timeout_set;
    logic [1:0]        fwd_a, fwd_b;
    logic              lw_stall;

    forward_unit u_fwd_a (
        .rs_e_i        (rs1_e_i),
        .rd_m_i        (rd_m_i),
        .rd_w_i        (rd_w_i),
        .reg_write_m_i (reg_write_m_i),
        .reg_write_w_i (reg_write_w_i),
        .fwd_o         (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (rs2_e_i),
        .rd_m_i        (rd_m_i),
        .rd_w_i        (rd_w_i),
        .reg_write_m_i (reg_write_m_i),
        .reg_write_w_i (reg_write_w_i),
        .fwd_o         (fwd_b)
    );

    assign forward_ae_o = rst_i ? FWD_RF : fwd_a;
    assign forward_be_o = rst_i ? FWD_RF : fwd_b;

    assign lw_stall = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != 5'd0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    // Controls are gated by rst_i so they drop as soon as reset asserts.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_set = 1'b0;
        mc_start_o  = 1'b0;
        stall_f_o   = 1'b0;
        stall_d_o   = 1'b0;
        stall_e_o   = 1'b0;
        flush_d_o   = 1'b0;
        flush_e_o   = 1'b0;
        flush_m_o   = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                RUN: begin
                    if (mc_op_e_i) begin
                        mc_start_o = 1'b1;
                        stall_f_o  = 1'b1;
                        stall_d_o  = 1'b1;
                        stall_e_o  = 1'b1;
                        flush_m_o  = 1'b1;
                        state_d    = MC_WAIT;
                        timer_d    = '0;
                    end else begin
                        stall_f_o = lw_stall;
                        stall_d_o = lw_stall;
                        flush_d_o = pc_src_e_i;
                        flush_e_o = lw_stall | pc_src_e_i;
                    end
                end
                MC_WAIT: begin
                    if (mc_done_i) begin
                        state_d = RUN;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d     = RUN;
                        timeout_set = 1'b1;
                    end else begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        stall_e_o = 1'b1;
                        flush_m_o = 1'b1;
                        timer_d   = timer_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            timer_q   <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_q | timeout_set;
            if (stall_f_o && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign mc_timeout_o  = timeout_q;
    assign stall_count_o = count_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencer for the 5-stage RV32 core datapath. It produces the datapath's forwarding selects and its stall and flush controls. It resolves load-use and control hazards. It also sequences multi-cycle execute-stage units (M-extension divide/multiply) through a start/done handshake, freezing the front of the pipeline until the unit finishes. A saturating stall-cycle counter and a sticky timeout flag are provided for debug.

Parameters:
MC_TIMEOUT, 64, max cycles in MC_WAIT before forced release; must be >=2
PERF_W, 32, width of stall-cycle counter

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
rs1_d_i  in  5  decode-stage source register 1 (instr_d[19:15])
rs2_d_i  in  5  decode-stage source register 2 (instr_d[24:20])
rs1_e_i  in  5  execute-stage rs1
rs2_e_i  in  5  execute-stage rs2
rd_e_i  in  5  execute-stage destination
rd_m_i  in  5  memory-stage destination
rd_w_i  in  5  writeback-stage destination
reg_write_m_i  in  1  M-stage instruction writes rd
reg_write_w_i  in  1  W-stage instruction writes rd
result_src_e_i  in  2  E-stage result select; 2'b01 = load
pc_src_e_i  in  1  taken branch/jump resolved in E
mc_op_e_i  in  1  E-stage instruction needs the multi-cycle unit
mc_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
mc_start_o  out  1  start pulse to multi-cycle unit
forward_ae_o  out  2  src A select: 00 regfile, 01 result_w, 10 alu_result_m
forward_be_o  out  2  src B select, same encoding
stall_f_o  out  1  hold PC
stall_d_o  out  1  hold F/D registers
stall_e_o  out  1  hold D/E registers
flush_d_o  out  1  clear F/D registers
flush_e_o  out  1  clear D/E registers
flush_m_o  out  1  clear E/M registers (bubble)
mc_timeout_o  out  1  sticky: a multi-cycle op timed out
stall_count_o  out  PERF_W  cycles with stall_f_o=1, saturating

Behaviour:
- FSM states: RUN, MC_WAIT. Reset -> RUN, timer=0, stall_count_o=0, mc_timeout_o=0.
- While rst_i=1, all stall, flush and mc_start outputs are 0, and forward selects are 00.
- Forwarding (combinational, all states) for src A:
  - 10 if reg_write_m_i && rd_m_i==rs1_e_i && rs1_e_i!=0;
  - else 01 if reg_write_w_i && rd_w_i==rs1_e_i && rs1_e_i!=0;
  - else 00. M has priority over W.
  - src B: identical, using rs2_e_i.
- lw_stall = (result_src_e_i==2'b01) && rd_e_i!=0 && (rd_e_i==rs1_d_i || rd_e_i==rs2_d_i).
- RUN, mc_op_e_i=0:
  - stall_f=stall_d=lw_stall; stall_e=0;
  - flush_d=pc_src_e_i; flush_e=lw_stall|pc_src_e_i; flush_m=0.
- RUN, mc_op_e_i=1:
  - mc_start_o=1 for this cycle only;
  - stall_f=stall_d=stall_e=1, flush_m=1, flush_d=flush_e=0; lw_stall and pc_src_e_i ignored;
  - next state MC_WAIT, timer cleared.
- MC_WAIT, mc_done_i=0 and timer<MC_TIMEOUT-1:
  - stall F/D/E, flush_m=1, timer++.
- MC_WAIT, mc_done_i=1:
  - release this cycle: stall_f/d/e=0, flush_m=0; E instruction advances with its result; next state RUN.
- MC_WAIT, timer==MC_TIMEOUT-1 without mc_done_i:
  - same release, mc_timeout_o set (sticky until reset), next state RUN.
- mc_done_i in RUN is ignored.
- Minimum multi-cycle occupancy is 2 cycles (start cycle + done cycle).
- A load-use hazard in D while in MC_WAIT is re-evaluated in RUN after release. Flush_e is never asserted while E holds the multi-cycle op.
- stall_count_o increments every cycle stall_f_o=1 and saturates at all-ones.
- Reset mid-operation: FSM returns to RUN immediately. mc_start_o is reissued only if mc_op_e_i is still 1 after reset deasserts.

Decomposition:
- Package core_pkg: FSM enum (RUN, MC_WAIT), forward encodings (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), RESULT_SRC_LOAD=2'b01.
- Sub-module forward_unit: combinational, instantiated twice, once per ALU source.

Test Plan:
- Forwarding: rd_m=5 with reg_write_m=1, rd_w=5 with reg_write_w=1, rs1_e=5 -> forward_ae=10; rs2_e=0 with rd_m=0 -> forward_be=00.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly one cycle; stall_count_o increments by 1.
- Branch with load-use: pc_src_e=1 and lw_stall=1 in the same cycle -> flush_d=1, flush_e=1, stall_f=1.
- Divide: mc_op_e=1 and mc_done pulsed 5 cycles later -> mc_start_o high for 1 cycle; stall_f/d/e and flush_m high for 5 cycles; release on the done cycle; stall_count_o=5.
- Timeout: MC_TIMEOUT=8, no mc_done -> release after 8 stalled cycles; mc_timeout_o=1 and stays 1; mc_done arriving later in RUN has no effect.
- Reset: assert rst_i during MC_WAIT -> all stall/flush outputs drop asynchronously, stall_count_o=0; after deassert with mc_op_e=1 -> a new mc_start_o pulse.
